// File: rtl/pcpi_div_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pcpi_div_initiator: CPU-side PCPI master, one command at a time, with    |
// | no-claim timeout and busy watchdog.            Revision: 1.0             |
// +--------------------------------------------------------------------------+
module pcpi_div_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WAIT_LIMIT     = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [31:0] rsp_rd,
  output logic [1:0]  rsp_status,
  output logic [15:0] rsp_cycles,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NOCLAIM = 2'b01;
  localparam logic [1:0] ST_WDOG    = 2'b10;

  localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] WAIT_U    = 32'(WAIT_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        claimed_q, claimed_d;
  logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic        rsp_wr_q, rsp_wr_d;
  logic [31:0] rsp_rd_q, rsp_rd_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [15:0] rsp_cycles_q, rsp_cycles_d;

  logic [15:0] cnt_step;
  logic        claimed_now, timeout_hit, wdog_hit, issue_done;

  // Limits are judged on the count including the current cycle.
  always_comb begin
    cnt_step    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    claimed_now = claimed_q | pcpi_wait;
    timeout_hit = !claimed_now && (32'(cnt_step) >= TIMEOUT_U);
    wdog_hit    = claimed_now && (32'(cnt_step) >= WAIT_U);
    issue_done  = pcpi_ready || timeout_hit || wdog_hit;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_ISSUE;
      S_ISSUE: if (issue_done) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = resetn && (state_q == S_IDLE);
    pcpi_valid = (state_q == S_ISSUE);
    rsp_valid  = (state_q == S_RESP);
    pcpi_insn  = insn_q;
    pcpi_rs1   = rs1_q;
    pcpi_rs2   = rs2_q;
    rsp_wr     = rsp_wr_q;
    rsp_rd     = rsp_rd_q;
    rsp_status = rsp_status_q;
    rsp_cycles = rsp_cycles_q;
  end

  always_comb begin
    cnt_d        = cnt_q;
    claimed_d    = claimed_q;
    insn_d       = insn_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rsp_wr_d     = rsp_wr_q;
    rsp_rd_d     = rsp_rd_q;
    rsp_status_d = rsp_status_q;
    rsp_cycles_d = rsp_cycles_q;
    if (state_q == S_IDLE && cmd_valid) begin
      insn_d    = cmd_insn;
      rs1_d     = cmd_rs1;
      rs2_d     = cmd_rs2;
      cnt_d     = 16'd0;
      claimed_d = 1'b0;
    end else if (state_q == S_ISSUE) begin
      cnt_d     = cnt_step;
      claimed_d = claimed_now;
      if (issue_done) begin
        rsp_cycles_d = cnt_step;
        // A result arriving on the same cycle as either limit still wins.
        if (pcpi_ready) begin
          rsp_status_d = ST_OK;
          rsp_wr_d     = pcpi_wr;
          rsp_rd_d     = pcpi_wr ? pcpi_rd : 32'd0;
        end else begin
          rsp_status_d = timeout_hit ? ST_NOCLAIM : ST_WDOG;
          rsp_wr_d     = 1'b0;
          rsp_rd_d     = 32'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q        <= 16'd0;
      claimed_q    <= 1'b0;
      insn_q       <= 32'd0;
      rs1_q        <= 32'd0;
      rs2_q        <= 32'd0;
      rsp_wr_q     <= 1'b0;
      rsp_rd_q     <= 32'd0;
      rsp_status_q <= 2'b00;
      rsp_cycles_q <= 16'd0;
    end else begin
      cnt_q        <= cnt_d;
      claimed_q    <= claimed_d;
      insn_q       <= insn_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_rd_q     <= rsp_rd_d;
      rsp_status_q <= rsp_status_d;
      rsp_cycles_q <= rsp_cycles_d;
    end
  end

endmodule
`default_nettype wire
